fmlarb_dack_pipe: RTL and testbench
===================================

Name: fmlarb_dack_pipe

Overview:
- Parametrised ack generator for an FML arbiter port.
- Converts the controller's early-ack (eack) into a data-phase ack, with independent read and write latencies.
- Allows up to MAX_OUT outstanding transactions, and masks the master strobe when a new request would overrun the outstanding limit or collide on the ack line.
- Sits between each arbiter master port and the SDRAM controller's early-ack output.

Parameters:
RD_LAT, 5, cycles from read eack to ack (range 1..16; 5 = CL2, 6 = CL3).
WR_LAT, 2, cycles from write eack to ack (range 1..16).
MAX_OUT, 1, maximum outstanding (eacked, not yet acked) transactions (range 1..8).
CNT_W, $clog2(MAX_OUT+1), width of the outstanding counter (derived; not overridden).

Ports:
sys_clk  in  1  system clock.
sys_rst_n  in  1  reset; asynchronous, active-low.
stb  in  1  raw strobe from master.
we  in  1  direction of current request (1 = write); valid with stb.
eack  in  1  early ack from controller; only legal while stbm=1.
stbm  out  1  masked strobe to controller (combinational).
ack  out  1  registered data-phase ack, one cycle per transaction.
ack_we  out  1  direction of the transaction acked this cycle; valid with ack.
outstanding  out  CNT_W  current outstanding count.
err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
Reset:
- Async assert; all registers clear: ack=0, ack_we=0, outstanding=0, err=0, schedule empty.
- stbm follows stb after reset.
- Reset mid-operation discards all pending acks; no ack is produced after release for pre-reset eacks.

Latency:
- eack high in cycle t with we=w produces ack=1 in exactly cycle t+L for one cycle, ack_we=w.
- L = RD_LAT when w=0, WR_LAT when w=1.

Schedule:
- Shift vector of depth max(RD_LAT,WR_LAT); each entry holds valid plus direction bit.
- Entry j means an ack is due in j cycles.
- Shifts every cycle. eack inserts an entry at position L.

Collision hazard:
- conflict = entry at position L(we) already valid, i.e. an earlier transaction acks in the same future cycle.
- Only possible when RD_LAT != WR_LAT.

Outstanding counter:
- +1 on eack, -1 on ack; unchanged when both occur in the same cycle.
- full = (outstanding == MAX_OUT).

Strobe mask:
- stbm = stb & ~full & ~conflict.
- With MAX_OUT=1, stbm is low from t+1 through t+L inclusive after an eack in cycle t.
- stbm is high again in t+L+1.

Illegal and boundary cases:
- eack while stbm=0: the transaction is still scheduled and counted, but the counter saturates at MAX_OUT.
- ack at outstanding=0 cannot occur by construction.
- Counter saturates at 0 and MAX_OUT; it never wraps.

Optional Feature:
- Macro FMLARB_DACK_ERR_CHECK_EN.
- Defined: err is set and held until reset on any of:
  - eack while stbm=0;
  - eack while a conflict exists;
  - counter saturation event.
- Undefined: err tied 0 and no checking logic is synthesised. Ack and mask behaviour are identical in both builds.

Decomposition:
- Shared package fmlarb_pkg holds:
  - default latency constants FML_RD_LAT_CL2=5, FML_RD_LAT_CL3=6, FML_WR_LAT=2;
  - the limit MAX_OUT_LIMIT=8;
  - the schedule entry struct {valid, we}.
- One sub-module, fmlarb_dack_sched:
  - parametrised delay-line schedule;
  - insert port (position, dir), peek port for conflict, head output.
- Top level holds the counter, mask, ack register and error logic.

Test Plan:
1. Defaults (RD_LAT=5, WR_LAT=2, MAX_OUT=1): read eack at cycle 10.
   - Expect ack=1, ack_we=0 at cycle 15 only.
   - Expect stbm=0 in cycles 11..15 and stbm=1 in cycle 16.
2. Defaults: write eack at cycle 10.
   - Expect ack=1, ack_we=1 at cycle 12.
   - Expect outstanding=1 in cycles 11..12, then 0 in cycle 13.
3. MAX_OUT=4, RD_LAT=6: back-to-back read eacks at cycles 0..3.
   - Expect acks at cycles 6..7..8..9.
   - Expect stbm=0 in cycles 4..6 (full), stbm=1 again at cycle 7.
4. MAX_OUT=4, RD_LAT=5, WR_LAT=2: read eack at cycle 0, stb=1 with we=1 held at cycle 3.
   - Expect stbm=0 at cycle 3 (conflict at cycle 5).
   - Expect stbm=1 at cycle 4; a write eack there acks at cycle 6.
5. Mid-operation reset: read eack at cycle 0, sys_rst_n low in cycle 2, released at cycle 3.
   - Expect no ack in cycles 3..10 and outstanding=0.
6. With FMLARB_DACK_ERR_CHECK_EN: eack forced at cycle 3 of test 1 (stbm=0).
   - Expect err=1 from cycle 4, held until reset.
   - Without the macro, err stays 0.

Source files
------------

// File: rtl/fmlarb_pkg.sv
// fmlarb_pkg: shared latency defaults, limits and schedule entry type
// for the FML arbiter data-phase ack path.
package fmlarb_pkg;
   localparam int FML_RD_LAT_CL2 = 5;
   localparam int FML_RD_LAT_CL3 = 6;
   localparam int FML_WR_LAT     = 2;
   localparam int MAX_OUT_LIMIT  = 8;
   localparam int POS_W          = 5;
   typedef struct packed {
      logic valid;
      logic we;
   } sched_ent_t;
endpackage

// File: rtl/fmlarb_dack_sched.sv
// fmlarb_dack_sched: delay-line schedule; entry j holds an ack due j cycles from now.
module fmlarb_dack_sched
   import fmlarb_pkg::*;
#(
   parameter int DEPTH = FML_RD_LAT_CL2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ins_i,
   input  logic [POS_W-1:0] ins_pos_i,
   input  logic             ins_we_i,
   input  logic [POS_W-1:0] peek_pos_i,
   output logic             peek_valid_o,
   output sched_ent_t       head_o
);
   sched_ent_t [DEPTH:1] sch_q, sch_d;
   sched_ent_t           new_ent;
   always_comb begin
      new_ent      = '{valid: 1'b1, we: ins_we_i};
      sch_d        = sch_q >> $bits(sched_ent_t);
      peek_valid_o = 1'b0;
      for (int j = 1; j < DEPTH; j++)
         if (ins_i && ins_pos_i == POS_W'(j + 1)) sch_d[j] = new_ent;
      for (int j = 1; j <= DEPTH; j++)
         if (peek_pos_i == POS_W'(j) && sch_q[j].valid) peek_valid_o = 1'b1;
      // a latency-1 insert bypasses the line straight to the ack register
      head_o = (ins_i && ins_pos_i == POS_W'(1)) ? new_ent : sch_q[1];
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) sch_q <= '0;
      else         sch_q <= sch_d;
endmodule

// File: rtl/fmlarb_dack_pipe.sv
// fmlarb_dack_pipe: turns controller eack into a data-phase ack and masks the strobe
// on outstanding overrun or ack collision; FMLARB_DACK_ERR_CHECK_EN enables sticky err.
module fmlarb_dack_pipe
   import fmlarb_pkg::*;
#(
   parameter int  RD_LAT  = FML_RD_LAT_CL2,
   parameter int  WR_LAT  = FML_WR_LAT,
   parameter int  MAX_OUT = 1,
   localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             stb,
   input  logic             we,
   input  logic             eack,
   output logic             stbm,
   output logic             ack,
   output logic             ack_we,
   output logic [CNT_W-1:0] outstanding,
   output logic             err
);
   localparam int DEPTH = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   logic [POS_W-1:0] lat;
   logic             conflict, full, inc, dec, ack_q, ack_we_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   sched_ent_t       head;
   assign lat = we ? POS_W'(WR_LAT) : POS_W'(RD_LAT);
   fmlarb_dack_sched #(.DEPTH(DEPTH)) u_sched (
      .clk_i        (sys_clk),
      .rst_ni       (sys_rst_n),
      .ins_i        (eack),
      .ins_pos_i    (lat),
      .ins_we_i     (we),
      .peek_pos_i   (lat),
      .peek_valid_o (conflict),
      .head_o       (head)
   );
   always_comb begin
      full  = cnt_q == CNT_W'(MAX_OUT);
      stbm  = stb & ~full & ~conflict;
      inc   = eack & ~ack_q;
      dec   = ack_q & ~eack;
      cnt_d = (inc && !full) ? cnt_q + CNT_W'(1) :
              (dec && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         ack_q    <= 1'b0;
         ack_we_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         ack_q    <= head.valid;
         ack_we_q <= head.we;
         cnt_q    <= cnt_d;
      end
   assign ack         = ack_q;
   assign ack_we      = ack_we_q;
   assign outstanding = cnt_q;
`ifdef FMLARB_DACK_ERR_CHECK_EN
   logic err_q;
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) err_q <= 1'b0;
      else            err_q <= err_q | (eack & ~stbm) | (eack & conflict) |
                               (inc & full) | (dec & (cnt_q == '0));
   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_fmlarb_dack_pipe.sv
// tb_fmlarb_dack_pipe: three parameterisations driven side by side against an
// absolute-cycle ack calendar model.
module tb_fmlarb_dack_pipe;
   localparam int N = 3;
   localparam int RDL [N] = '{5, 6, 5};
   localparam int WRL [N] = '{2, 2, 2};
   localparam int MOL [N] = '{1, 4, 4};
   logic sys_clk = 1'b0, sys_rst_n = 1'b0;
   logic [N-1:0] stb = '0, we = '0, eack = '0;
   logic [N-1:0] stbm, ack, ack_we, err;
   logic [N-1:0][3:0] outs;
   int n_chk = 0, n_fail = 0, cyc = 0;
   logic mv [N][64];
   logic mw [N][64];
   int   mcnt [N];
   logic merr [N];
   always #5 sys_clk = ~sys_clk;
   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [$clog2(MOL[g]+1)-1:0] o;
      fmlarb_dack_pipe #(.RD_LAT(RDL[g]), .WR_LAT(WRL[g]), .MAX_OUT(MOL[g])) u_dut (
         .sys_clk     (sys_clk),
         .sys_rst_n   (sys_rst_n),
         .stb         (stb[g]),
         .we          (we[g]),
         .eack        (eack[g]),
         .stbm        (stbm[g]),
         .ack         (ack[g]),
         .ack_we      (ack_we[g]),
         .outstanding (o),
         .err         (err[g])
      );
      assign outs[g] = 4'(o);
   end
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
      end
   endtask
   function automatic int lat(int g, logic w);
      return w ? WRL[g] : RDL[g];
   endfunction
   function automatic logic exp_stbm(int g, logic s, logic w);
      return s && (mcnt[g] < MOL[g]) && !mv[g][(cyc + lat(g, w)) % 64];
   endfunction
   task automatic model_clear();
      for (int g = 0; g < N; g++) begin
         for (int k = 0; k < 64; k++) begin
            mv[g][k] = 1'b0;
            mw[g][k] = 1'b0;
         end
         mcnt[g] = 0;
         merr[g] = 1'b0;
      end
   endtask
   task automatic advance(input int g, input logic e, input logic w, input logic es);
      logic a;
      logic inc, dec;
      a   = mv[g][cyc % 64];
      inc = e && !a;
      dec = a && !e;
`ifdef FMLARB_DACK_ERR_CHECK_EN
      if (e && (!es || (inc && mcnt[g] == MOL[g]) || (dec && mcnt[g] == 0))) merr[g] = 1'b1;
`else
      if (es && 1'b0) merr[g] = 1'b1;
`endif
      mv[g][cyc % 64] = 1'b0;
      if (e) begin
         mv[g][(cyc + lat(g, w)) % 64] = 1'b1;
         mw[g][(cyc + lat(g, w)) % 64] = w;
      end
      if (inc && mcnt[g] < MOL[g]) mcnt[g]++;
      else if (dec && mcnt[g] > 0) mcnt[g]--;
   endtask
   task automatic check_outputs();
      for (int g = 0; g < N; g++) begin
         check($sformatf("ack%0d", g), 32'(ack[g]), 32'(mv[g][cyc % 64]));
         if (mv[g][cyc % 64]) check($sformatf("ack_we%0d", g), 32'(ack_we[g]), 32'(mw[g][cyc % 64]));
         check($sformatf("outstanding%0d", g), 32'(outs[g]), 32'(mcnt[g]));
         check($sformatf("err%0d", g), 32'(err[g]), 32'(merr[g]));
      end
   endtask
   task automatic run(input logic [N-1:0] s, input logic [N-1:0] w,
                      input logic [N-1:0] e, input logic [N-1:0] fe);
      logic [N-1:0] es;
      stb = s;
      we  = w;
      #1;
      for (int g = 0; g < N; g++) begin
         es[g] = exp_stbm(g, s[g], w[g]);
         check($sformatf("stbm%0d", g), 32'(stbm[g]), 32'(es[g]));
         eack[g] = fe[g] | (e[g] & es[g]);
      end
      @(posedge sys_clk);
      for (int g = 0; g < N; g++) advance(g, eack[g], w[g], es[g]);
      cyc++;
      #1;
      check_outputs();
   endtask
   task automatic idle(input int n);
      repeat (n) run('0, '0, '0, '0);
   endtask
   task automatic reset_mid();
      eack = '0;
      stb  = '0;
      #2 sys_rst_n = 1'b0;
      #1;
      model_clear();
      check_outputs();
      @(posedge sys_clk);
      cyc++;
      #1 sys_rst_n = 1'b1;
      check_outputs();
   endtask
   initial begin
      model_clear();
      stb = '1;
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_stbm", 32'(stbm), 32'(stb));
      check_outputs();
      sys_rst_n = 1'b1;
      idle(3);
      run(3'b001, 3'b000, 3'b001, '0);
      repeat (7) run(3'b001, 3'b000, '0, '0);
      run(3'b001, 3'b001, 3'b001, '0);
      repeat (4) run(3'b001, 3'b001, '0, '0);
      repeat (4) run(3'b010, '0, 3'b010, '0);
      repeat (4) run(3'b010, '0, '0, '0);
      idle(8);
      run(3'b100, '0, 3'b100, '0);
      idle(2);
      run(3'b100, 3'b100, 3'b100, '0);
      run(3'b100, 3'b100, 3'b100, '0);
      idle(8);
      run(3'b001, '0, 3'b001, '0);
      idle(1);
      reset_mid();
      idle(8);
      run(3'b001, '0, 3'b001, '0);
      repeat (2) run(3'b001, '0, '0, '0);
      run(3'b001, '0, '0, 3'b001);
      idle(12);
      reset_mid();
      idle(2);
      repeat (3000) run(N'($urandom), N'($urandom), N'($urandom), '0);
      idle(20);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
